// File: rtl/fprint_comparator.sv
// fprint_comparator: pairs per-core task check-ins and compares both cores' fingerprint RAM ranges.
// Define COMP_EARLY_EXIT_EN to stop fetching at the first mismatching pair.
module fprint_comparator #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int KEY_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              checkin_valid,
    input  logic [KEY_W-1:0]  checkin_task,
    input  logic              checkin_core,
    output logic [KEY_W-1:0]  comp_task,
    input  logic [ADDR_W-1:0] start_pointer_comp,
    input  logic [ADDR_W-1:0] end_pointer_comp,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    input  logic [DATA_W-1:0] ram_rdata_0,
    input  logic [DATA_W-1:0] ram_rdata_1,
    output logic              comp_status_write,
    input  logic              comp_status_ack,
    output logic              comp_collision_detected,
    output logic              checkin_error
);
    localparam int NT = 1 << KEY_W;
    typedef enum logic [2:0] {IDLE, SELECT, PTR_WAIT, FETCH, DRAIN, REPORT} state_t;
    state_t state, state_nx;
    logic [NT-1:0] pend0, pend1, pend0_nx, pend1_nx, ready, clr_mask, set_mask;
    logic [KEY_W-1:0] pick;
    logic [ADDR_W-1:0] addr, end_q;
    logic mismatch, rd_q, miss_now, stop, clr, dup;
    assign ready = pend0 & pend1;
    assign clr = state == SELECT;
    assign miss_now = rd_q && (ram_rdata_0 != ram_rdata_1);
`ifdef COMP_EARLY_EXIT_EN
    assign stop = miss_now;
`else
    assign stop = 1'b0;
`endif
    assign ram_read = (state == FETCH) && !stop;
    assign ram_address = addr;
    assign comp_status_write = state == REPORT;
    assign comp_collision_detected = (state == REPORT) && mismatch;
    always_comb begin
        pick = '0;
        for (int i = NT - 1; i >= 0; i--)
            if (ready[i]) pick = KEY_W'(i);
    end
    // a check-in landing in the SELECT cycle for the selected task is applied after the clear
    always_comb begin
        clr_mask = clr ? ({{(NT-1){1'b0}}, 1'b1} << comp_task) : '0;
        set_mask = checkin_valid ? ({{(NT-1){1'b0}}, 1'b1} << checkin_task) : '0;
        pend0_nx = (pend0 & ~clr_mask) | (checkin_core ? '0 : set_mask);
        pend1_nx = (pend1 & ~clr_mask) | (checkin_core ? set_mask : '0);
        dup = checkin_valid && (checkin_core ? pend1[checkin_task] : pend0[checkin_task])
              && !(clr && checkin_task == comp_task);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = |ready ? SELECT : IDLE;
            SELECT:   state_nx = PTR_WAIT;
            PTR_WAIT: state_nx = FETCH;
            FETCH:    state_nx = (stop || addr == end_q) ? DRAIN : FETCH;
            DRAIN:    state_nx = REPORT;
            REPORT:   state_nx = comp_status_ack ? IDLE : REPORT;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pend0         <= '0;
            pend1         <= '0;
            comp_task     <= '0;
            addr          <= '0;
            end_q         <= '0;
            mismatch      <= 1'b0;
            rd_q          <= 1'b0;
            checkin_error <= 1'b0;
        end else begin
            state         <= state_nx;
            pend0         <= pend0_nx;
            pend1         <= pend1_nx;
            rd_q          <= ram_read;
            checkin_error <= dup;
            mismatch      <= clr ? 1'b0 : (mismatch | miss_now);
            if (state == IDLE && |ready) comp_task <= pick;
            if (state == PTR_WAIT) begin
                addr  <= start_pointer_comp;
                end_q <= end_pointer_comp;
            end else if (ram_read) begin
                addr <= addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fprint_comparator.sv
// tb_fprint_comparator: directed checks of fprint_comparator with behavioural RAM and pointer table.
module tb_fprint_comparator;
    localparam int AW = 9, DW = 32, KW = 4;
    logic clk = 0, reset_n = 0, checkin_valid = 0, checkin_core = 0, comp_status_ack = 0;
    logic [KW-1:0] checkin_task = 0, comp_task;
    logic [AW-1:0] start_pointer_comp, end_pointer_comp, ram_address;
    logic ram_read, comp_status_write, comp_collision_detected, checkin_error;
    logic [DW-1:0] ram_rdata_0, ram_rdata_1;
    logic [DW-1:0] mem0 [512];
    logic [DW-1:0] mem1 [512];
    logic [AW-1:0] sp [16];
    logic [AW-1:0] ep [16];
    logic [AW-1:0] rlog [$];
    int checks = 0, errors = 0, cyc;

    fprint_comparator #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW)) dut (
        .clk(clk), .reset_n(reset_n),
        .checkin_valid(checkin_valid), .checkin_task(checkin_task), .checkin_core(checkin_core),
        .comp_task(comp_task), .start_pointer_comp(start_pointer_comp), .end_pointer_comp(end_pointer_comp),
        .ram_address(ram_address), .ram_read(ram_read), .ram_rdata_0(ram_rdata_0), .ram_rdata_1(ram_rdata_1),
        .comp_status_write(comp_status_write), .comp_status_ack(comp_status_ack),
        .comp_collision_detected(comp_collision_detected), .checkin_error(checkin_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        start_pointer_comp <= sp[comp_task];
        end_pointer_comp   <= ep[comp_task];
        if (ram_read) begin
            ram_rdata_0 <= mem0[ram_address];
            ram_rdata_1 <= mem1[ram_address];
            rlog.push_back(ram_address);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkin(input int t, input logic c);
        @(negedge clk);
        checkin_valid = 1;
        checkin_task = t[3:0];
        checkin_core = c;
        @(negedge clk);
        checkin_valid = 0;
    endtask

    task automatic wait_report(input int max, output int n);
        n = 0;
        while (!comp_status_write && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack();
        comp_status_ack = 1;
        @(negedge clk);
        comp_status_ack = 0;
        chk("ack_release", comp_status_write, 0);
    endtask

    task automatic chk_reads(input string tag, input int s, input int n);
        chk({tag, "_nreads"}, rlog.size(), n);
        for (int i = 0; i < n && i < rlog.size(); i++)
            chk({tag, "_addr"}, rlog[i], (s + i) % 512);
        rlog.delete();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = $urandom;
            mem1[i] = mem0[i];
        end
        for (int i = 0; i < 16; i++) begin
            sp[i] = 0;
            ep[i] = 0;
        end
        sp[3] = 10;  ep[3] = 13;
        sp[5] = 20;  ep[5] = 22;
        sp[6] = 510; ep[6] = 1;
        sp[1] = 30;  ep[1] = 30;
        sp[2] = 40;  ep[2] = 41;
        sp[7] = 50;  ep[7] = 50;
        sp[4] = 60;  ep[4] = 60;
        sp[8] = 70;  ep[8] = 71;
        sp[9] = 100; ep[9] = 150;
        mem1[21] = mem0[21] ^ 32'h1;

        repeat (2) @(negedge clk);
        chk("rst_read", ram_read, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_task", comp_task, 0);
        chk("rst_write", comp_status_write, 0);
        chk("rst_coll", comp_collision_detected, 0);
        chk("rst_err", checkin_error, 0);
        reset_n = 1;

        checkin(3, 0);
        checkin(3, 1);
        wait_report(30, cyc);
        chk("t3_latency", cyc, 8);
        chk("t3_write", comp_status_write, 1);
        chk("t3_task", comp_task, 3);
        chk("t3_coll", comp_collision_detected, 0);
        chk_reads("t3", 10, 4);
        ack();

        checkin(5, 1);
        checkin(5, 0);
        wait_report(30, cyc);
        chk("t5_latency", cyc, 7);
        chk("t5_task", comp_task, 5);
        chk("t5_coll", comp_collision_detected, 1);
`ifdef COMP_EARLY_EXIT_EN
        chk_reads("t5", 20, 2);
`else
        chk_reads("t5", 20, 3);
`endif
        ack();

        checkin(6, 0);
        checkin(6, 1);
        wait_report(30, cyc);
        chk("wrap_latency", cyc, 8);
        chk("wrap_coll", comp_collision_detected, 0);
        chk_reads("wrap", 510, 4);
        ack();

        checkin(1, 0);
        checkin(1, 1);
        wait_report(30, cyc);
        chk("single_latency", cyc, 5);
        chk_reads("single", 30, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_write", comp_status_write, 1);
        end
        checkin(7, 0);
        checkin(7, 1);
        checkin(2, 0);
        checkin(2, 1);
        chk("hold_task", comp_task, 1);
        ack();
        wait_report(30, cyc);
        chk("prio_first", comp_task, 2);
        chk_reads("prio2", 40, 2);
        ack();
        wait_report(30, cyc);
        chk("prio_second", comp_task, 7);
        chk("prio_write", comp_status_write, 1);
        chk_reads("prio7", 50, 1);
        ack();

        checkin(4, 0);
        chk("dup_first", checkin_error, 0);
        checkin(4, 0);
        chk("dup_pulse", checkin_error, 1);
        @(negedge clk);
        chk("dup_once", checkin_error, 0);
        checkin(4, 1);
        wait_report(30, cyc);
        chk("dup_latency", cyc, 5);
        chk("dup_task", comp_task, 4);
        rlog.delete();
        ack();
        wait_report(15, cyc);
        chk("dup_no_requeue", comp_status_write, 0);

        checkin(8, 0);
        checkin(8, 1);
        checkin(8, 0);
        wait_report(30, cyc);
        chk("sel_task", comp_task, 8);
        ack();
        checkin(8, 1);
        wait_report(30, cyc);
        chk("sel_requeue", comp_status_write, 1);
        chk("sel_latency", cyc, 6);
        rlog.delete();
        ack();

        checkin(9, 0);
        checkin(9, 1);
        repeat (5) @(negedge clk);
        chk("mid_fetch", ram_read, 1);
        reset_n = 0;
        #1;
        chk("mrst_read", ram_read, 0);
        chk("mrst_addr", ram_address, 0);
        chk("mrst_task", comp_task, 0);
        chk("mrst_write", comp_status_write, 0);
        chk("mrst_coll", comp_collision_detected, 0);
        @(negedge clk);
        reset_n = 1;
        wait_report(80, cyc);
        chk("mrst_no_report", comp_status_write, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
